// File: rtl/instr_fetch.sv
// Nibble-wide instruction fetch unit: reads one- or two-nibble instructions from a
// synchronous program memory. Optional wrap-error handling via INSTR_FETCH_WRAP_ERR_EN.
module instr_fetch #(
  parameter logic [3:0] RESET_PC    = 4'h0,
  parameter int         LONG_OP_BIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] instr_op,
  output logic [3:0] instr_arg,
  output logic [3:0] instr_pc,
  output logic       instr_len,
  input  logic       jump_valid,
  input  logic [3:0] jump_addr,
  output logic       fetch_err,
  output logic [2:0] dbg_state
);

  // Handshake: a bundle transfers on a rising edge where instr_valid && instr_ready;
  // instr_valid never drops and bundle fields never change until that edge.
  typedef enum logic [2:0] {
    ISSUE_OP  = 3'd0,
    CAPT_OP   = 3'd1,
    ISSUE_ARG = 3'd2,
    CAPT_ARG  = 3'd3,
    OUT       = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_pc;
  logic [3:0] r_op;
  logic [3:0] r_arg;
  logic [3:0] r_ipc;
  logic       r_len;
  logic [3:0] w_pc_inc;
  logic       w_long;

`ifdef INSTR_FETCH_WRAP_ERR_EN
  logic       r_wrap;
`endif

  assign w_pc_inc = r_pc + 4'd1;
  assign w_long   = mem_data[LONG_OP_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ISSUE_OP;
      r_pc    <= RESET_PC;
      r_op    <= 4'h0;
      r_arg   <= 4'h0;
      r_ipc   <= 4'h0;
      r_len   <= 1'b0;
`ifdef INSTR_FETCH_WRAP_ERR_EN
      r_wrap  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ISSUE_OP: r_state <= CAPT_OP;
        CAPT_OP: begin
          r_op  <= mem_data;
          r_ipc <= r_pc;
          r_pc  <= w_pc_inc;
          if (w_long) begin
            r_state <= ISSUE_ARG;
          end else begin
            r_state <= OUT;
            r_arg   <= 4'h0;
            r_len   <= 1'b0;
          end
`ifdef INSTR_FETCH_WRAP_ERR_EN
          // A long opcode at the last address has no operand slot left.
          if (r_pc == 4'hF) begin
            r_wrap <= 1'b1;
            if (w_long) r_state <= ERR;
          end
`endif
        end
        ISSUE_ARG: r_state <= CAPT_ARG;
        CAPT_ARG: begin
          r_arg   <= mem_data;
          r_len   <= 1'b1;
          r_pc    <= w_pc_inc;
          r_state <= OUT;
`ifdef INSTR_FETCH_WRAP_ERR_EN
          if (r_pc == 4'hF) r_wrap <= 1'b1;
`endif
        end
        OUT: begin
          if (instr_ready) begin
            r_state <= ISSUE_OP;
`ifdef INSTR_FETCH_WRAP_ERR_EN
            if (r_wrap) r_state <= ERR;
`endif
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= ISSUE_OP;
      endcase
      // Redirect overrides everything above; an OUT handshake on this edge still counts.
      if (jump_valid) begin
        r_pc    <= jump_addr;
        r_state <= ISSUE_OP;
`ifdef INSTR_FETCH_WRAP_ERR_EN
        r_wrap  <= 1'b0;
`endif
      end
    end
  end

  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == OUT);
  assign instr_op    = r_op;
  assign instr_arg   = r_arg;
  assign instr_pc    = r_ipc;
  assign instr_len   = r_len;
  assign dbg_state   = r_state;

`ifdef INSTR_FETCH_WRAP_ERR_EN
  assign fetch_err = (r_state == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency, hold under backpressure, redirect,
// address wrap and mid-bundle reset, with a synchronous program-memory model.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n, rst4_n;
  logic [3:0] mem_addr, mem_addr4;
  logic [3:0] mem_data, mem_data4;
  logic       instr_valid, instr_valid4;
  logic       instr_ready, instr_ready4;
  logic [3:0] instr_op, instr_arg, instr_pc;
  logic [3:0] instr_op4, instr_arg4, instr_pc4;
  logic       instr_len, instr_len4;
  logic       jump_valid;
  logic [3:0] jump_addr;
  logic       fetch_err, fetch_err4;
  logic [2:0] dbg_state, dbg_state4;

  logic [3:0]  mem [16];
  logic [12:0] exp_q [$];
  int          n_checks;
  int          n_errors;
  int          n;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_arg(instr_arg), .instr_pc(instr_pc), .instr_len(instr_len),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .fetch_err(fetch_err),
    .dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(4'h4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .mem_addr(mem_addr4), .mem_data(mem_data4),
    .instr_valid(instr_valid4), .instr_ready(instr_ready4),
    .instr_op(instr_op4), .instr_arg(instr_arg4), .instr_pc(instr_pc4), .instr_len(instr_len4),
    .jump_valid(1'b0), .jump_addr(4'h0), .fetch_err(fetch_err4),
    .dbg_state(dbg_state4)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    mem_data  <= mem[mem_addr];
    mem_data4 <= mem[mem_addr4];
  end

  // Scoreboard
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_bundle(input string tag);
    logic [12:0] e;
    e = exp_q.pop_front();
    check({tag, "_op"},  {12'h0, instr_op},  {12'h0, e[12:9]});
    check({tag, "_arg"}, {12'h0, instr_arg}, {12'h0, e[8:5]});
    check({tag, "_len"}, {15'h0, instr_len}, {15'h0, e[4]});
    check({tag, "_pc"},  {12'h0, instr_pc},  {12'h0, e[3:0]});
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!instr_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[0]  = 4'h2;
    mem[1]  = 4'h9;
    mem[2]  = 4'h5;
    mem[3]  = 4'h8;
    mem[4]  = 4'h1;
    mem[5]  = 4'h6;
    mem[10] = 4'h3;
`ifdef INSTR_FETCH_WRAP_ERR_EN
    mem[15] = 4'h1;
`else
    mem[15] = 4'h8;
`endif
    rst_n = 1'b0; rst4_n = 1'b0;
    instr_ready = 1'b1; instr_ready4 = 1'b0;
    jump_valid = 1'b0; jump_addr = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_addr",  {12'h0, mem_addr},  16'h0);
    check("rst_valid", {15'h0, instr_valid}, 16'h0);
    check("rst_op",    {12'h0, instr_op},  16'h0);
    check("rst_arg",   {12'h0, instr_arg}, 16'h0);
    check("rst_pc",    {12'h0, instr_pc},  16'h0);
    check("rst_len",   {15'h0, instr_len}, 16'h0);
    check("rst_err",   {15'h0, fetch_err}, 16'h0);
    check("rst_addr4", {12'h0, mem_addr4}, 16'h4);
    rst_n = 1'b1; rst4_n = 1'b1;

    // Short opcode, then long opcode with backpressure
    exp_q.push_back({4'h2, 4'h0, 1'b0, 4'h0});
    wait_valid(n);
    check("lat_short", n[15:0], 16'd2);
    check_bundle("b0");
    step();
    instr_ready = 1'b0;
    exp_q.push_back({4'h9, 4'h5, 1'b1, 4'h1});
    wait_valid(n);
    check("lat_long", n[15:0], 16'd4);
    check_bundle("b1");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {15'h0, instr_valid}, 16'h1);
      check("hold_data", {3'h0, instr_op, instr_arg, instr_len, instr_pc}, {3'h0, 4'h9, 4'h5, 1'b1, 4'h1});
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("post_hs_addr",  {12'h0, mem_addr},    16'h3);
    check("post_hs_valid", {15'h0, instr_valid}, 16'h0);

    // Redirect during CAPT_ARG of the long opcode at 3
    repeat (3) step();
    check("in_capt_arg", {13'h0, dbg_state}, 16'd3);
    jump_valid = 1'b1; jump_addr = 4'hA;
    step();
    jump_valid = 1'b0;
    check("jmp_addr",  {12'h0, mem_addr},    16'hA);
    check("jmp_valid", {15'h0, instr_valid}, 16'h0);
    exp_q.push_back({4'h3, 4'h0, 1'b0, 4'hA});
    wait_valid(n);
    check("lat_jmp", n[15:0], 16'd2);
    check_bundle("b2");

    // Handshake and redirect to F on the same edge
    instr_ready = 1'b1; jump_valid = 1'b1; jump_addr = 4'hF;
    step();
    instr_ready = 1'b0; jump_valid = 1'b0;
    check("hs_jmp_addr",  {12'h0, mem_addr},    16'hF);
    check("hs_jmp_valid", {15'h0, instr_valid}, 16'h0);

`ifdef INSTR_FETCH_WRAP_ERR_EN
    exp_q.push_back({4'h1, 4'h0, 1'b0, 4'hF});
    wait_valid(n);
    check("lat_wrap", n[15:0], 16'd2);
    check_bundle("b3");
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("err_set",   {15'h0, fetch_err},   16'h1);
      check("err_valid", {15'h0, instr_valid}, 16'h0);
      step();
    end
    jump_valid = 1'b1; jump_addr = 4'h0;
    step();
    jump_valid = 1'b0;
    check("err_clr",      {15'h0, fetch_err}, 16'h0);
    check("err_clr_addr", {12'h0, mem_addr},  16'h0);
    mem[15] = 4'h8;
    jump_valid = 1'b1; jump_addr = 4'hF;
    step();
    jump_valid = 1'b0;
    repeat (2) step();
    check("err_long",       {15'h0, fetch_err},   16'h1);
    check("err_long_valid", {15'h0, instr_valid}, 16'h0);
    jump_valid = 1'b1; jump_addr = 4'h0;
    step();
    jump_valid = 1'b0;
    check("err_long_clr", {15'h0, fetch_err}, 16'h0);
`else
    exp_q.push_back({4'h8, 4'h2, 1'b1, 4'hF});
    wait_valid(n);
    check("lat_wrap", n[15:0], 16'd4);
    check_bundle("b3");
    check("wrap_err", {15'h0, fetch_err}, 16'h0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_addr",  {12'h0, mem_addr},    16'h1);
    check("wrap_err2",  {15'h0, fetch_err},   16'h0);
    check("wrap_valid", {15'h0, instr_valid}, 16'h0);
`endif

    // Reset during OUT on the RESET_PC=4 instance (held in OUT since startup)
    check("r4_valid", {15'h0, instr_valid4}, 16'h1);
    check("r4_pc",    {12'h0, instr_pc4},    16'h4);
    rst4_n = 1'b0;
    step();
    rst4_n = 1'b1;
    check("r4_rst_valid", {15'h0, instr_valid4}, 16'h0);
    check("r4_rst_addr",  {12'h0, mem_addr4},    16'h4);
    n = 0;
    while (!instr_valid4 && n < 20) begin
      step();
      n++;
    end
    check("r4_lat",    n[15:0], 16'd2);
    check("r4_new_pc", {12'h0, instr_pc4}, 16'h4);
    check("r4_new_op", {12'h0, instr_op4}, 16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
